// File: rtl/dff_reg_arbiter.sv
// ---------------------------------------------------------------------------
// dff_reg_arbiter
//
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit
// register. Up to NREQ requesters offer data over a valid/ready handshake.
// The arbiter grants one requester, loads its data into the shared register
// on the following edge, then idles for HOLD_CYC cycles before it arbitrates
// again. Priority rotates to the requester after the one just written.
//
// Parameters:
//   NREQ      number of requesters (2..8)
//   WIDTH     shared register width
//   HOLD_CYC  idle cycles after each completed write (0 = none)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   req_valid  bit i: requester i has data to write
//   req_data   requester i data in bits [i*WIDTH +: WIDTH]
//   req_lock   (ARB_LOCK_EN only) bit i: requester i keeps the grant
//   req_ready  one-hot grant, high for exactly one cycle per grant
//   grant_id   index of the last/current grant
//   q          shared register value
//   qn         always ~q
//   upd        one-cycle pulse when q shows newly written data
//   busy       high while the sequencer is not idle
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, a requester that writes with its req_lock bit set keeps
//   the grant: the pointer does not advance and the next arbitration
//   regrants it directly while it stays valid.
// ---------------------------------------------------------------------------
module dff_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qn,
  output logic                    upd,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  // The hold counter runs 0 .. HOLD_CYC-1, so it needs at least one bit
  // even when there is no hold phase at all.
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    ptr, ptr_d;
  logic [IW-1:0]    grant_d;
  logic [NREQ-1:0]  ready_d;
  logic [WIDTH-1:0] q_d;
  logic             upd_d;
  logic [HW-1:0]    hold_cnt, cnt_d;
  logic [WIDTH-1:0] sel_data;

  logic [IW-1:0]    scan_base;
  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    cand;
  logic             scan_found;

`ifdef ARB_LOCK_EN
  logic             lock_active, lock_d;
`endif

  // Modulo-NREQ increment that also works for non-power-of-two NREQ.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // The round-robin scan normally starts at the pointer. When a lock is
  // released because the locked requester went away, the pointer moves past
  // it and the scan in that same cycle already starts from the new position.
`ifdef ARB_LOCK_EN
  always_comb begin
    scan_base = ptr;
    if (lock_active && !req_valid[grant_id]) begin
      scan_base = next_idx(grant_id);
    end
  end
`else
  always_comb begin
    scan_base = ptr;
  end
`endif

  // First asserted request found walking scan_base, scan_base+1, ... with
  // wrap-around. The walk carries the candidate index instead of using a
  // modulo so that odd NREQ values need no divider.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = scan_base;
    for (int k = 0; k < NREQ; k++) begin
      if (!scan_found && req_valid[cand]) begin
        scan_found = 1'b1;
        scan_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Next-state and next-output logic. Every register in the block gets its
  // next value here; req_ready and upd default low so they can only ever
  // pulse for a single cycle.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    grant_d  = grant_id;
    ready_d  = '0;
    q_d      = q;
    upd_d    = 1'b0;
    cnt_d    = hold_cnt;
    sel_data = req_data[grant_id*WIDTH +: WIDTH];
`ifdef ARB_LOCK_EN
    lock_d   = lock_active;
`endif

    unique case (state)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (lock_active && req_valid[grant_id]) begin
          ready_d[grant_id] = 1'b1;
          state_d           = WRITE;
        end else begin
          if (lock_active) begin
            ptr_d  = scan_base;
            lock_d = 1'b0;
          end
          if (scan_found) begin
            ready_d[scan_idx] = 1'b1;
            grant_d           = scan_idx;
            state_d           = WRITE;
          end
        end
`else
        if (scan_found) begin
          ready_d[scan_idx] = 1'b1;
          grant_d           = scan_idx;
          state_d           = WRITE;
        end
`endif
      end

      WRITE: begin
        if (req_valid[grant_id]) begin
          q_d   = sel_data;
          upd_d = 1'b1;
`ifdef ARB_LOCK_EN
          if (req_lock[grant_id]) begin
            lock_d = 1'b1;
          end else begin
            lock_d = 1'b0;
            ptr_d  = next_idx(grant_id);
          end
`else
          ptr_d = next_idx(grant_id);
`endif
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Withdrawn request: nothing is written and priority stays put.
`ifdef ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
          state_d = IDLE;
        end
      end

      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. busy is registered from the next state so
  // that it lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      q         <= '0;
      upd       <= 1'b0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_active <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      grant_id  <= grant_d;
      req_ready <= ready_d;
      q         <= q_d;
      upd       <= upd_d;
      hold_cnt  <= cnt_d;
      busy      <= (state_d != IDLE);
`ifdef ARB_LOCK_EN
      lock_active <= lock_d;
`endif
    end
  end

  // The complement output is decoded from q so it can never disagree.
  assign qn = ~q;

endmodule
